mem_cache_ctrl: RTL and testbench
=================================

// Module: mem_cache_ctrl
// PURPOSE
//  Data-memory front end consumed by MEM_stage; sits between the MEM stage and the off-chip SRAM.
//  Direct-mapped read cache, one 16-bit word per line. Write-through, no-write-allocate.
//  Raises freeze to stall the whole pipeline while an SRAM access is in flight.
//  Reports hit for the current read.
// PARAMETERS
//  ADDR_W      16  word address width from MEM stage
//  INDEX_BITS  6   cache index width (2**INDEX_BITS lines)
//  SRAM_WAIT   1   extra SRAM wait cycles per access (0..7)
// PORTS
//  clk        in   1       clock; all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  mem_rd_en  in   1       load request (held stable while freeze=1)
//  mem_wr_en  in   1       store request (held stable while freeze=1)
//  cache_en   in   1       0: every read misses, no fills, no updates
//  addr       in   ADDR_W  word address
//  wr_data    in   16      store data
//  rd_data    out  16      load data
//  freeze     out  1       1: pipeline must hold all stage registers
//  hit        out  1       current read hits the cache
//  SRAM_DQ    inout 16     SRAM data bus
//  SRAM_ADDR  out  18      {zero-extend, addr}
//  SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each; active-low strobes
// BEHAVIOUR
//  - Address split: index = addr[INDEX_BITS-1:0], tag = addr[ADDR_W-1:INDEX_BITS].
//  - Line state: valid bit, tag, 16-bit data.
//  - FSM states: IDLE, ACCESS, DONE.
//  - IDLE:
//      hit = mem_rd_en & ~mem_wr_en & cache_en & valid & tag match (combinational).
//      Read hit: rd_data = line data in the same cycle, freeze=0, state stays IDLE.
//      Read miss or any write: freeze=1 in the same cycle.
//        wait counter <= SRAM_WAIT; state -> ACCESS.
//      If mem_rd_en and mem_wr_en are both 1, the request is treated as a write.
//  - ACCESS:
//      freeze=1, SRAM_CE_N=0, UB_N=0, LB_N=0.
//      Read: OE_N=0, WE_N=1, DQ=Z.
//      Write: WE_N=0, OE_N=1, DQ driven with wr_data.
//      Counter decrements each cycle. When the counter is 0, the last cycle does the following:
//        read: capture SRAM_DQ into the fill register; if cache_en, write the line (valid=1, tag, data).
//        write: if cache_en and the line hits, update the line data.
//        state -> DONE.
//  - DONE:
//      freeze=0, hit=0, all strobes high, DQ=Z.
//      rd_data = fill register (read) or 0 (write).
//      State -> IDLE unconditionally. Request inputs in DONE are never re-sampled.
//  - Latency: freeze is high for SRAM_WAIT+2 consecutive cycles per miss or store.
//      With the default SRAM_WAIT=1 that is 3 cycles.
//  - No request (rd=wr=0) in IDLE: freeze=0, hit=0, rd_data=0, strobes high.
//  - Outputs after reset:
//      state IDLE; all valid bits 0; fill register 0.
//      freeze=0, hit=0, rd_data=0.
//      SRAM_WE_N, OE_N, CE_N, UB_N, LB_N = 1; SRAM_DQ = Z.
//      SRAM_ADDR = addr (pass-through).
//  - Reset mid-ACCESS: the access is aborted. No line update occurs, and a write may be partially applied in SRAM.
//  - SRAM_DQ is driven only in ACCESS during a write. It is never driven in the same cycle as OE_N=0.
// TESTING
//  1. rst pulse while idle -> freeze=0, hit=0, rd_data=0, all strobes 1, DQ=Z, all lines invalid.
//  2. Cold read of 0x0041, SRAM returns 0xBEEF -> freeze=1 for 3 cycles, then rd_data=0xBEEF.
//     Repeating the read gives hit=1 and rd_data=0xBEEF with no freeze.
//  3. Write 0x1234 to 0x0041 (cached) -> WE_N low 2 cycles with DQ=0x1234 and freeze 3 cycles.
//     A following read of 0x0041 hits and returns 0x1234.
//  4. Read 0x0041, then read 0x0081 (same index, new tag) -> miss and refill.
//     A read of 0x0041 afterwards misses again.
//  5. rst asserted in the 2nd ACCESS cycle of a read miss -> next cycle IDLE, freeze=0, DQ=Z.
//     A re-read of the same address misses.
//  6. cache_en=0: two reads of 0x0010 -> both miss, each freezes 3 cycles, hit never 1.
//     With SRAM_WAIT=0 the freeze is 2 cycles.

Source files
------------

// File: rtl/mem_cache_ctrl.sv
// rtl/mem_cache_ctrl.sv - direct-mapped write-through read cache in front of an async SRAM
module mem_cache_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int INDEX_BITS = 6,
  parameter int SRAM_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic              cache_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wr_data,
  output logic [15:0]       rd_data,
  output logic              freeze,
  output logic              hit,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [2:0]       wait_q;
  logic             is_wr_q;
  logic [15:0]      fill_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  line_match;
  logic                  req;
  logic                  last_access;
  logic                  line_we;
  logic [15:0]           line_data_d;
  logic                  dq_oe;

  assign index      = addr[INDEX_BITS-1:0];
  assign tag        = addr[ADDR_W-1:INDEX_BITS];
  assign line_match = valid_q[index] && (tag_q[index] == tag);

  // A simultaneous read+write request is handled as a write, so it never hits.
  assign req = mem_rd_en | mem_wr_en;
  assign hit = (state_q == ST_IDLE) & mem_rd_en & ~mem_wr_en & cache_en & line_match;

  // Line update happens on the final SRAM cycle: reads always fill (when
  // caching is on), writes only refresh a line that already holds the address.
  assign last_access = (state_q == ST_ACCESS) && (wait_q == 3'd0);
  assign line_we     = last_access && cache_en && (!is_wr_q || line_match);
  assign line_data_d = is_wr_q ? wr_data : SRAM_DQ;

  assign SRAM_ADDR = 18'(addr);
  assign SRAM_DQ   = dq_oe ? wr_data : 16'hzzzz;

  // Controller FSM, wait counter, fill register and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 3'd0;
      is_wr_q <= 1'b0;
      fill_q  <= 16'h0000;
      valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && !hit) begin
            state_q <= ST_ACCESS;
            wait_q  <= 3'(SRAM_WAIT);
            is_wr_q <= mem_wr_en;
          end
        end
        ST_ACCESS: begin
          if (wait_q == 3'd0) begin
            if (!is_wr_q) begin
              fill_q <= SRAM_DQ;
            end
            if (line_we) begin
              valid_q[index] <= 1'b1;
            end
            state_q <= ST_DONE;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag/data storage; no reset needed because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= line_data_d;
    end
  end

  // Pipeline handshake and SRAM strobes decoded from the current state.
  always_comb begin
    freeze    = 1'b0;
    rd_data   = 16'h0000;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        freeze = req & ~hit;
        if (hit) begin
          rd_data = data_q[index];
        end
      end
      ST_ACCESS: begin
        freeze    = 1'b1;
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (is_wr_q) begin
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      ST_DONE: begin
        rd_data = is_wr_q ? 16'h0000 : fill_q;
      end
      default: begin
        freeze = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb/tb_mem_cache_ctrl.sv - self-checking bench for mem_cache_ctrl
module tb_mem_cache_ctrl;

  localparam int W  = 1;
  localparam int MF = W + 2;

  logic        clk, rst, mem_rd_en, mem_wr_en, cache_en;
  logic [15:0] addr, wr_data, rd_data;
  logic        freeze, hit;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  logic        rd0, c_en0;
  logic [15:0] addr0, rdata0;
  logic        frz0, hit0;
  wire  [15:0] dq0;
  logic [17:0] sram0_addr;
  logic        we0_n, oe0_n, ce0_n, ub0_n, lb0_n;

  int checks;
  int failures;

  mem_cache_ctrl #(.ADDR_W(16), .INDEX_BITS(6), .SRAM_WAIT(W)) dut (
    .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .cache_en(cache_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .freeze(freeze), .hit(hit), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  mem_cache_ctrl #(.ADDR_W(16), .INDEX_BITS(6), .SRAM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .mem_rd_en(rd0), .mem_wr_en(1'b0),
    .cache_en(c_en0), .addr(addr0), .wr_data(16'h0000), .rd_data(rdata0),
    .freeze(frz0), .hit(hit0), .SRAM_DQ(dq0), .SRAM_ADDR(sram0_addr),
    .SRAM_WE_N(we0_n), .SRAM_OE_N(oe0_n), .SRAM_CE_N(ce0_n),
    .SRAM_UB_N(ub0_n), .SRAM_LB_N(lb0_n)
  );

  always #5 clk = ~clk;

  // SRAM model shared by both instances (only the main one writes)
  logic [15:0] sram_mem [1024];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) sram_mem[pre_a] <= pre_d;
    else if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
  end

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR[9:0]] : 16'hzzzz;
  assign dq0     = (!ce0_n && !oe0_n) ? sram_mem[sram0_addr[9:0]] : 16'hzzzz;

  // Reference model: memory image plus a 64-entry direct-mapped cache
  logic [15:0] ref_mem [1024];
  logic        ref_v   [64];
  logic [9:0]  ref_tag [64];
  logic [15:0] ref_dat [64];

  typedef struct {
    logic        rd, wr, ce;
    logic [15:0] a, d;
    logic        e_hit;
    int          e_fr;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic rd, logic wr, logic ce, logic [15:0] a, logic [15:0] d,
                              logic eh, int ef, logic [15:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ce = ce; v.a = a; v.d = d;
    v.e_hit = eh; v.e_fr = ef; v.e_rd = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic rd, input logic wr, input logic ce, input logic [15:0] a,
                       input logic [15:0] d, output logic e_hit, output int e_fr,
                       output logic [15:0] e_rd);
    int   idx;
    int   tg;
    logic lh;
    idx = int'(a) % 64;
    tg  = int'(a) / 64;
    lh  = ref_v[idx] && (ref_tag[idx] == 10'(tg));
    e_hit = 1'b0; e_fr = 0; e_rd = 16'h0000;
    if (wr) begin
      ref_mem[a[9:0]] = d;
      if (ce && lh) ref_dat[idx] = d;
      e_fr = MF;
    end else if (rd) begin
      if (ce && lh) begin
        e_hit = 1'b1;
        e_rd  = ref_dat[idx];
      end else begin
        e_fr = MF;
        e_rd = ref_mem[a[9:0]];
        if (ce) begin
          ref_v[idx]   = 1'b1;
          ref_tag[idx] = 10'(tg);
          ref_dat[idx] = e_rd;
        end
      end
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    ref_mem[a] = d;
    @(posedge clk); #1;
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic ce, input logic [15:0] a,
                         input logic [15:0] d, input logic e_hit, input int e_fr,
                         input logic [15:0] e_rd, input string nm);
    int   fr, we_cnt;
    logic first_hit, stray_hit, dq_bad, strobe_bad, done;
    @(posedge clk); #1;
    mem_rd_en = rd; mem_wr_en = wr; cache_en = ce; addr = a; wr_data = d;
    fr = 0; we_cnt = 0; first_hit = 1'b0; stray_hit = 1'b0;
    dq_bad = 1'b0; strobe_bad = 1'b0; done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (c == 0) first_hit = hit;
      else if (hit) stray_hit = 1'b1;
      if (!SRAM_WE_N) begin
        we_cnt++;
        if (SRAM_DQ !== d) dq_bad = 1'b1;
      end
      if (!SRAM_WE_N && !SRAM_OE_N) strobe_bad = 1'b1;
      if ((!SRAM_WE_N || !SRAM_OE_N) && ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} != 3'b000))
        strobe_bad = 1'b1;
      if (freeze) fr++;
      else done = 1'b1;
    end
    chk({nm, ".hit"}, 32'(first_hit), 32'(e_hit));
    chk({nm, ".freeze_cycles"}, fr, e_fr);
    chk({nm, ".rd_data"}, 32'(rd_data), 32'(e_rd));
    chk({nm, ".hit_while_busy"}, 32'(stray_hit), 32'd0);
    chk({nm, ".strobes"}, 32'(strobe_bad), 32'd0);
    if (wr) begin
      chk({nm, ".we_cycles"}, we_cnt, MF - 1);
      chk({nm, ".dq_data"}, 32'(dq_bad), 32'd0);
    end
  endtask

  task automatic run_model(input logic rd, input logic wr, input logic ce, input logic [15:0] a,
                           input logic [15:0] d, input string nm);
    logic        eh;
    int          ef;
    logic [15:0] er;
    model(rd, wr, ce, a, d, eh, ef, er);
    run_req(rd, wr, ce, a, d, eh, ef, er, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          fr;
    logic        hit_seen, done;
    logic        eh;
    int          ef;
    logic [15:0] er;
    clk = 1'b0; rst = 1'b1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; cache_en = 1'b0; addr = 16'h0123; wr_data = 16'h0000;
    rd0 = 1'b0; c_en0 = 1'b0; addr0 = 16'h0000;
    pre_we = 1'b0; pre_a = 10'h000; pre_d = 16'h0000;
    checks = 0; failures = 0;
    for (int i = 0; i < 64; i++) begin
      ref_v[i] = 1'b0; ref_tag[i] = 10'h000; ref_dat[i] = 16'h0000;
    end
    #1;
    for (int i = 0; i < 1024; i++) preload(10'(i), 16'(i) ^ 16'hC3C3);
    preload(10'h041, 16'hBEEF);
    preload(10'h081, 16'h5A5A);
    preload(10'h010, 16'h0F0F);
    preload(10'h082, 16'hABCD);
    pre_we = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset.freeze", 32'(freeze), 32'd0);
    chk("reset.hit", 32'(hit), 32'd0);
    chk("reset.rd_data", 32'(rd_data), 32'd0);
    chk("reset.strobes", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1f);
    chk("reset.sram_addr", 32'(SRAM_ADDR), 32'h00123);
    @(posedge clk); #1;
    rst = 1'b0;

    // SRAM_WAIT=0 instance with caching off: two reads, 2-cycle freeze each
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rd0 = 1'b1; c_en0 = 1'b0; addr0 = 16'h0010;
      fr = 0; hit_seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
        @(negedge clk);
        if (hit0) hit_seen = 1'b1;
        if (frz0) fr++;
        else done = 1'b1;
      end
      chk($sformatf("wait0.%0d.freeze_cycles", k), fr, 2);
      chk($sformatf("wait0.%0d.hit", k), 32'(hit_seen), 32'd0);
      chk($sformatf("wait0.%0d.rd_data", k), 32'(rdata0), 32'h0F0F);
    end
    @(posedge clk); #1;
    rd0 = 1'b0;

    // Directed table
    tbl[0]  = mk(1, 0, 1, 16'h0041, 16'h0000, 0, MF, 16'hBEEF);
    tbl[1]  = mk(1, 0, 1, 16'h0041, 16'h0000, 1, 0,  16'hBEEF);
    tbl[2]  = mk(0, 1, 1, 16'h0041, 16'h1234, 0, MF, 16'h0000);
    tbl[3]  = mk(1, 0, 1, 16'h0041, 16'h0000, 1, 0,  16'h1234);
    tbl[4]  = mk(1, 0, 1, 16'h0081, 16'h0000, 0, MF, 16'h5A5A);
    tbl[5]  = mk(1, 0, 1, 16'h0081, 16'h0000, 1, 0,  16'h5A5A);
    tbl[6]  = mk(1, 0, 1, 16'h0041, 16'h0000, 0, MF, 16'h1234);
    tbl[7]  = mk(0, 0, 1, 16'h0041, 16'h0000, 0, 0,  16'h0000);
    tbl[8]  = mk(1, 0, 0, 16'h0010, 16'h0000, 0, MF, 16'h0F0F);
    tbl[9]  = mk(1, 0, 0, 16'h0010, 16'h0000, 0, MF, 16'h0F0F);
    tbl[10] = mk(1, 0, 1, 16'h0010, 16'h0000, 0, MF, 16'h0F0F);
    tbl[11] = mk(1, 1, 1, 16'h0010, 16'h7777, 0, MF, 16'h0000);
    tbl[12] = mk(1, 0, 1, 16'h0010, 16'h0000, 1, 0,  16'h7777);
    tbl[13] = mk(1, 0, 0, 16'h0010, 16'h0000, 0, MF, 16'h7777);
    tbl[14] = mk(0, 1, 0, 16'h0010, 16'h1111, 0, MF, 16'h0000);
    tbl[15] = mk(1, 0, 1, 16'h0010, 16'h0000, 1, 0,  16'h7777);
    tbl[16] = mk(0, 1, 1, 16'h0050, 16'h2222, 0, MF, 16'h0000);
    tbl[17] = mk(1, 0, 1, 16'h0010, 16'h0000, 1, 0,  16'h7777);
    tbl[18] = mk(1, 0, 1, 16'h0050, 16'h0000, 0, MF, 16'h2222);
    tbl[19] = mk(1, 0, 1, 16'h0010, 16'h0000, 0, MF, 16'h1111);
    for (int i = 0; i < 20; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].ce, tbl[i].a, tbl[i].d, eh, ef, er);
      run_req(tbl[i].rd, tbl[i].wr, tbl[i].ce, tbl[i].a, tbl[i].d,
              tbl[i].e_hit, tbl[i].e_fr, tbl[i].e_rd, $sformatf("tbl%0d", i));
    end

    // Reset in the second ACCESS cycle of a read miss
    @(posedge clk); #1;
    mem_rd_en = 1'b1; mem_wr_en = 1'b0; cache_en = 1'b1; addr = 16'h0082;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.busy_before", 32'(freeze), 32'd1);
    rst = 1'b1; mem_rd_en = 1'b0;
    @(negedge clk);
    chk("midrst.freeze", 32'(freeze), 32'd0);
    chk("midrst.hit", 32'(hit), 32'd0);
    chk("midrst.rd_data", 32'(rd_data), 32'd0);
    chk("midrst.strobes", 32'({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1f);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
    run_req(1, 0, 1, 16'h0082, 16'h0000, 0, MF, 16'hABCD, "midrst.reread");
    run_req(1, 0, 1, 16'h0041, 16'h0000, 0, MF, 16'h1234, "midrst.other");
    model(1, 0, 1, 16'h0082, 16'h0000, eh, ef, er);
    model(1, 0, 1, 16'h0041, 16'h0000, eh, ef, er);

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      int          r;
      logic        rd, wr, ce;
      logic [15:0] a, d;
      r  = int'($urandom_range(0, 9));
      rd = (r >= 1 && r <= 6) || (r == 9);
      wr = (r >= 7);
      ce = ($urandom_range(0, 4) != 0);
      a  = 16'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
      d  = 16'($urandom);
      run_model(rd, wr, ce, a, d, $sformatf("rnd%0d", n));
    end

    @(posedge clk); #1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
